w21_neuron_mac: RTL and testbench

- Downstream consumer of a layer-21 weight column ROM: one output neuron of the w21 fully-connected layer.
- Steps a shared row address through the weight ROM (combinational read) and the input activation buffer (synchronous read, 1-cycle latency).
- Multiply-accumulates all N_IN products, adds the bias, then scales, applies ReLU and saturates.
- Presents the result on a valid/ready output port. One instance per ROM column.

---
 rtl/w21_neuron_mac.sv | 226 ++++++++++++++++++++++
 tb/tb_w21_neuron_mac.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w21_neuron_mac.sv
// w21_neuron_mac: one output neuron of the w21 fully-connected layer.
// Walks a shared row address through the weight ROM (combinational read) and the
// activation buffer (1-cycle synchronous read). It multiply-accumulates all N_IN
// products and adds the bias, then scales, applies ReLU and saturates. The result
// is presented on a valid/ready output port.
module w21_neuron_mac #(
    parameter int unsigned N_IN   = 300,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned W_W    = 21,
    parameter int unsigned X_W    = 16,
    parameter int unsigned ACC_W  = 48,
    parameter int unsigned Y_W    = 16,
    parameter int unsigned SHIFT  = 8,
    parameter int unsigned RELU   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [W_W-1:0]    bias,
    output logic [ADDR_W-1:0] adrs_clm,
    input  logic [W_W-1:0]    w_in,
    output logic [ADDR_W-1:0] x_addr,
    input  logic [X_W-1:0]    x_data,
    output logic              busy,
    output logic [Y_W-1:0]    y,
    output logic              y_valid,
    input  logic              y_ready
);

    localparam int unsigned       P_W      = W_W + X_W;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_IN - 1);

    // Output saturation bounds, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] YMax =
        $signed({{(ACC_W - Y_W + 1){1'b0}}, {(Y_W - 1){1'b1}}});
    localparam logic signed [ACC_W-1:0] YMin =
        $signed({{(ACC_W - Y_W + 1){1'b1}}, {(Y_W - 1){1'b0}}});

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StOut
    } state_e;

    state_e r_state;
    state_e w_state_nxt;

    // FSM strobes
    logic w_accept;
    logic w_step;
    logic w_finish;
    logic w_handshake;

    // Datapath registers
    logic [ADDR_W-1:0]       r_adrs;
    logic [W_W-1:0]          r_bias;
    logic [W_W-1:0]          r_w_q;
    logic                    r_v1;
    logic [P_W-1:0]          r_p;
    logic                    r_v2;
    logic [ACC_W-1:0]        r_acc;
    logic [Y_W-1:0]          r_y;
    logic                    r_y_valid;

    // Datapath combinational signals
    logic [P_W-1:0]          w_w_ext;
    logic [P_W-1:0]          w_x_ext;
    logic [P_W-1:0]          w_prod;
    logic [ACC_W-1:0]        w_p_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shr;
    logic signed [ACC_W-1:0] w_relu;
    logic signed [ACC_W-1:0] w_clamp;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        w_handshake = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                // Each RUN edge captures the weight for the current address.
                w_step = 1'b1;
                if (r_adrs == LastAddr) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                // Both pipeline stages empty means the last product is in acc.
                if (!r_v1 && !r_v2) begin
                    w_finish    = 1'b1;
                    w_state_nxt = StOut;
                end
            end
            StOut: begin
                if (y_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Row address: cleared on accept, advances in RUN, holds at the last row
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_adrs <= '0;
        end else if (w_accept) begin
            r_adrs <= '0;
        end else if (w_step && (r_adrs != LastAddr)) begin
            r_adrs <= r_adrs + ADDR_W'(1);
        end
    end

    // Bias is captured only on the accepted start edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bias <= '0;
        end else if (w_accept) begin
            r_bias <= bias;
        end
    end

    // Stage 1: register the ROM weight alongside the activation read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_q <= '0;
            r_v1  <= 1'b0;
        end else begin
            r_v1 <= w_step;
            if (w_step) begin
                r_w_q <= w_in;
            end
        end
    end

    // Full-width signed product; low P_W bits of the extended multiply are exact.
    always_comb begin
        w_w_ext = {{X_W{r_w_q[W_W-1]}}, r_w_q};
        w_x_ext = {{W_W{x_data[X_W-1]}}, x_data};
        w_prod  = w_w_ext * w_x_ext;
        w_p_ext = {{(ACC_W - P_W){r_p[P_W-1]}}, r_p};
    end

    // Stage 2: product register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p  <= '0;
            r_v2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_p <= w_prod;
            end
        end
    end

    // Stage 3: accumulator, wraps modulo 2^ACC_W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (r_v2) begin
            r_acc <= r_acc + w_p_ext;
        end
    end

    // Bias add, arithmetic scale, optional ReLU, then saturation to Y_W
    always_comb begin
        w_sum  = $signed(r_acc + {{(ACC_W - W_W){r_bias[W_W-1]}}, r_bias});
        w_shr  = w_sum >>> SHIFT;
        w_relu = w_shr;
        if ((RELU != 0) && w_shr[ACC_W-1]) begin
            w_relu = '0;
        end
        if (w_relu > YMax) begin
            w_clamp = YMax;
        end else if (w_relu < YMin) begin
            w_clamp = YMin;
        end else begin
            w_clamp = w_relu;
        end
    end

    // Output register: y holds its value after the handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else if (w_finish) begin
            r_y       <= w_clamp[Y_W-1:0];
            r_y_valid <= 1'b1;
        end else if (w_handshake) begin
            r_y_valid <= 1'b0;
        end
    end

    assign adrs_clm = r_adrs;
    assign x_addr   = r_adrs;
    assign busy     = (r_state != StIdle);
    assign y        = r_y;
    assign y_valid  = r_y_valid;

endmodule

// File: tb/tb_w21_neuron_mac.sv
// Testbench for w21_neuron_mac. Four instances share stimulus with different
// SHIFT/RELU settings. A behavioural weight ROM and a 1-cycle activation buffer
// sit around each instance.
module tb_w21_neuron_mac;

    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        y_ready = 1'b0;
    logic [20:0] bias = '0;

    logic [8:0]  adrs [NC];
    logic [8:0]  xa [NC];
    logic [20:0] w_in [NC];
    logic [15:0] x_data [NC];
    logic        busy [NC];
    logic        yv [NC];
    logic [15:0] y [NC];
    logic [15:0] exp_y [NC];
    logic [15:0] held_y [NC];

    logic signed [15:0] x_mem [512];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic int cfg_sh(int g);
        return (g == 2) ? 4 : ((g == 3) ? 8 : 0);
    endfunction

    function automatic bit cfg_relu(int g);
        return (g == 0) || (g == 3);
    endfunction

    // Column contents: rows 0 and 1 are fixed, the rest pseudo-random in range.
    function automatic logic [20:0] rom_w(int k);
        int v;
        if (k == 0) v = 310;
        else if (k == 1) v = -560;
        else v = ((k * 7919) % 1999999) - 999999;
        return v[20:0];
    endfunction

    function automatic logic [15:0] to16(int v);
        return v[15:0];
    endfunction

    function automatic logic [15:0] model(int g, logic [20:0] b);
        longint acc;
        acc = 0;
        for (int k = 0; k < 300; k++) begin
            acc += longint'($signed(rom_w(k))) * longint'(x_mem[k]);
        end
        acc += longint'($signed(b));
        acc = acc >>> cfg_sh(g);
        if (cfg_relu(g) && acc < 0) acc = 0;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        return acc[15:0];
    endfunction

    for (genvar g = 0; g < NC; g++) begin : g_dut
        w21_neuron_mac #(
            .N_IN  (300),
            .ADDR_W(9),
            .W_W   (21),
            .X_W   (16),
            .ACC_W (48),
            .Y_W   (16),
            .SHIFT ((g == 2) ? 4 : ((g == 3) ? 8 : 0)),
            .RELU  ((g == 0 || g == 3) ? 1 : 0)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start),
            .bias    (bias),
            .adrs_clm(adrs[g]),
            .w_in    (w_in[g]),
            .x_addr  (xa[g]),
            .x_data  (x_data[g]),
            .busy    (busy[g]),
            .y       (y[g]),
            .y_valid (yv[g]),
            .y_ready (y_ready)
        );
        assign w_in[g] = rom_w(int'(adrs[g]));
        always @(posedge clk) x_data[g] <= x_mem[xa[g]];
    end

    task automatic clear_x();
        for (int k = 0; k < 512; k++) x_mem[k] = '0;
    endtask

    // Called at a negedge; pulses start, waits (bounded) for y_valid and tallies
    // cycles where an address is off its expected position.
    task automatic launch(input logic [20:0] b, output int lat, output int bad);
        int ea;
        lat = 0;
        bad = 0;
        bias = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bias = b ^ 21'h0AAAA;
        while (yv[0] !== 1'b1 && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            ea = (lat < 299) ? lat : 299;
            for (int g = 0; g < NC; g++) begin
                if (adrs[g] !== xa[g] || adrs[g] !== 9'(ea)) bad++;
            end
        end
    endtask

    task automatic handshake();
        y_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        y_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NC; g++) begin
            n_vec++;
            if (adrs[g] !== 9'd0 || xa[g] !== 9'd0 || busy[g] !== 1'b0 ||
                yv[g] !== 1'b0 || y[g] !== 16'd0) begin
                n_err++;
                $display("FAIL reset[%0d]: adrs=%0d xa=%0d busy=%b yv=%b y=%0d, want all 0",
                         g, adrs[g], xa[g], busy[g], yv[g], y[g]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        int lat, bad;
        clear_x();
        exp_y = '{to16(5), to16(5), to16(0), to16(0)};
        launch(21'd5, lat, bad);
        n_vec++;
        if (lat !== 303) begin
            n_err++;
            $display("FAIL latency: got %0d cycles, want 303", lat);
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL latency_addr: %0d bad address cycles, want 0", bad);
        end
        for (int g = 0; g < NC; g++) begin
            n_vec++;
            if (y[g] !== exp_y[g] || yv[g] !== 1'b1 || busy[g] !== 1'b1) begin
                n_err++;
                $display("FAIL latency_y[%0d]: y=%0d yv=%b busy=%b, want y=%0d yv=1 busy=1",
                         g, $signed(y[g]), yv[g], busy[g], $signed(exp_y[g]));
            end
        end
        handshake();
        for (int g = 0; g < NC; g++) begin
            n_vec++;
            if (busy[g] !== 1'b0 || yv[g] !== 1'b0 || y[g] !== exp_y[g]) begin
                n_err++;
                $display("FAIL latency_done[%0d]: busy=%b yv=%b y=%0d, want 0 0 %0d",
                         g, busy[g], yv[g], $signed(y[g]), $signed(exp_y[g]));
            end
        end
    endtask

    task automatic test_single_input();
        int lat, bad;
        clear_x();
        x_mem[0] = 16'sd1;
        exp_y = '{to16(310), to16(310), to16(19), to16(1)};
        launch(21'd0, lat, bad);
        for (int g = 0; g < NC; g++) begin
            n_vec++;
            if (y[g] !== exp_y[g]) begin
                n_err++;
                $display("FAIL row0[%0d]: y=%0d, want %0d", g, $signed(y[g]), $signed(exp_y[g]));
            end
        end
        handshake();
        clear_x();
        x_mem[1] = 16'sd1;
        exp_y = '{to16(0), to16(-560), to16(-35), to16(0)};
        launch(21'd0, lat, bad);
        for (int g = 0; g < NC; g++) begin
            n_vec++;
            if (y[g] !== exp_y[g]) begin
                n_err++;
                $display("FAIL row1[%0d]: y=%0d, want %0d", g, $signed(y[g]), $signed(exp_y[g]));
            end
        end
        handshake();
    endtask

    task automatic test_saturation();
        int lat, bad;
        clear_x();
        exp_y = '{to16(32767), to16(32767), to16(32767), to16(4095)};
        launch(21'd1048575, lat, bad);
        for (int g = 0; g < NC; g++) begin
            n_vec++;
            if (y[g] !== exp_y[g]) begin
                n_err++;
                $display("FAIL sat_pos[%0d]: y=%0d, want %0d", g, $signed(y[g]), $signed(exp_y[g]));
            end
        end
        handshake();
        exp_y = '{to16(0), to16(-32768), to16(-32768), to16(0)};
        launch(21'h100000, lat, bad);
        for (int g = 0; g < NC; g++) begin
            n_vec++;
            if (y[g] !== exp_y[g]) begin
                n_err++;
                $display("FAIL sat_neg[%0d]: y=%0d, want %0d", g, $signed(y[g]), $signed(exp_y[g]));
            end
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat, bad;
        clear_x();
        x_mem[0] = 16'sd1;
        exp_y = '{to16(310), to16(310), to16(19), to16(1)};
        launch(21'd0, lat, bad);
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(posedge clk);
            @(negedge clk);
            for (int g = 0; g < NC; g++) begin
                n_vec++;
                if (yv[g] !== 1'b1 || busy[g] !== 1'b1 || y[g] !== exp_y[g]) begin
                    n_err++;
                    $display("FAIL hold[%0d] cyc %0d: yv=%b busy=%b y=%0d, want 1 1 %0d",
                             g, i, yv[g], busy[g], $signed(y[g]), $signed(exp_y[g]));
                end
            end
        end
        // Start coincident with the handshake edge must be ignored.
        start = 1'b1;
        y_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        y_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int g = 0; g < NC; g++) begin
                n_vec++;
                if (busy[g] !== 1'b0 || yv[g] !== 1'b0 || y[g] !== exp_y[g]) begin
                    n_err++;
                    $display("FAIL release[%0d] cyc %0d: busy=%b yv=%b y=%0d, want 0 0 %0d",
                             g, i, busy[g], yv[g], $signed(y[g]), $signed(exp_y[g]));
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bad;
        clear_x();
        x_mem[0] = 16'sd1;
        bias = '0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (adrs[0] !== 9'd100) begin
            n_err++;
            $display("FAIL midrun_addr: adrs=%0d, want 100", adrs[0]);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NC; g++) begin
            n_vec++;
            if (adrs[g] !== 9'd0 || busy[g] !== 1'b0 || yv[g] !== 1'b0) begin
                n_err++;
                $display("FAIL midrun_rst[%0d]: adrs=%0d busy=%b yv=%b, want 0 0 0",
                         g, adrs[g], busy[g], yv[g]);
            end
        end
        rst_n = 1'b1;
        exp_y = '{to16(310), to16(310), to16(19), to16(1)};
        launch(21'd0, lat, bad);
        n_vec++;
        if (lat !== 303) begin
            n_err++;
            $display("FAIL midrun_lat: got %0d cycles, want 303", lat);
        end
        for (int g = 0; g < NC; g++) begin
            n_vec++;
            if (y[g] !== exp_y[g]) begin
                n_err++;
                $display("FAIL midrun_y[%0d]: y=%0d, want %0d", g, $signed(y[g]), $signed(exp_y[g]));
            end
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat, bad;
        logic [20:0] b;
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 300; k++) x_mem[k] = 16'($urandom);
            b = 21'($urandom);
            for (int g = 0; g < NC; g++) exp_y[g] = model(g, b);
            launch(b, lat, bad);
            n_vec++;
            if (lat !== 303 || bad !== 0) begin
                n_err++;
                $display("FAIL b2b_seq run %0d: lat=%0d bad_addr=%0d, want 303 0", r, lat, bad);
            end
            for (int g = 0; g < NC; g++) begin
                n_vec++;
                if (y[g] !== exp_y[g]) begin
                    n_err++;
                    $display("FAIL b2b_y run %0d [%0d]: y=%0d, want %0d",
                             r, g, $signed(y[g]), $signed(exp_y[g]));
                end
            end
            handshake();
        end
    endtask

    initial begin
        clear_x();
        test_reset();
        test_latency();
        test_single_input();
        test_saturation();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
